// File: rtl/snoop_bus_initiator_pkg.sv
// snoop_bus_initiator_pkg: shared coherence encodings (MESI, snoop results, bus ops)
// and the snoop-result priority merge. Rev 1.0
`default_nettype none

package snoop_bus_initiator_pkg;

  typedef logic [1:0] mesi_t;
  typedef logic [1:0] snp_res_t;
  typedef logic [1:0] bus_op_t;

  localparam mesi_t MESI_M = 2'b00;
  localparam mesi_t MESI_E = 2'b01;
  localparam mesi_t MESI_S = 2'b10;
  localparam mesi_t MESI_I = 2'b11;

  localparam snp_res_t SNP_NOHIT = 2'b00;
  localparam snp_res_t SNP_HIT   = 2'b01;
  localparam snp_res_t SNP_HITM  = 2'b10;

  localparam bus_op_t OP_READ  = 2'b00;
  localparam bus_op_t OP_WRITE = 2'b01;
  localparam bus_op_t OP_RFO   = 2'b10;
  localparam bus_op_t OP_INV   = 2'b11;

  // Code 11 is folded onto HITM so the numeric maximum gives HITM > HIT > NOHIT.
  function automatic snp_res_t snp_merge(input snp_res_t a, input snp_res_t b);
    snp_res_t na;
    snp_res_t nb;
    na = a[1] ? SNP_HITM : a;
    nb = b[1] ? SNP_HITM : b;
    return (na > nb) ? na : nb;
  endfunction

endpackage

`default_nettype wire

// File: rtl/snoop_bus_initiator_collector.sv
// snoop_rsp_collector: per-peer response mask, aggregate result and COLLECT-phase
// timeout counter for the bus initiator. Rev 1.0
`default_nettype none

module snoop_rsp_collector
  import snoop_bus_initiator_pkg::*;
#(
  parameter int NUM_SNOOPERS = 3,
  parameter int TIMEOUT      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clear,
  input  logic                      i_active,
  input  logic [NUM_SNOOPERS-1:0]   i_rsp_valid,
  input  logic [2*NUM_SNOOPERS-1:0] i_rsp,
  output logic                      all_in,
  output logic                      timed_out,
  output logic [1:0]                agg
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_CNT_MAX  = CNT_W'(TIMEOUT);

  logic [NUM_SNOOPERS-1:0] r_mask;
  logic [1:0]              r_agg;
  logic [CNT_W-1:0]        r_cnt;
  logic [NUM_SNOOPERS-1:0] w_take;
  logic [1:0]              w_agg;

  // Aggregate includes this cycle's strobes so the exit decision sees them.
  always_comb begin
    w_take = i_active ? (i_rsp_valid & ~r_mask) : '0;
    w_agg  = r_agg;
    for (int i = 0; i < NUM_SNOOPERS; i++) begin
      if (w_take[i]) begin
        w_agg = snp_merge(w_agg, i_rsp[2*i +: 2]);
      end
    end
  end

  assign all_in    = &(r_mask | w_take);
  assign timed_out = i_active && (r_cnt == C_CNT_LAST);
  assign agg       = w_agg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask <= '0;
      r_agg  <= SNP_NOHIT;
      r_cnt  <= '0;
    end else if (i_clear) begin
      r_mask <= '0;
      r_agg  <= SNP_NOHIT;
      r_cnt  <= '0;
    end else if (i_active) begin
      r_mask <= r_mask | w_take;
      r_agg  <= w_agg;
      if (r_cnt != C_CNT_MAX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/snoop_bus_initiator.sv
// snoop_bus_initiator: issues one bus op to all peers, collects snoop results,
// waits for a HITM writeback and reports aggregate + fill state. Rev 1.0
`default_nettype none

module snoop_bus_initiator
  import snoop_bus_initiator_pkg::*;
#(
  parameter int NUM_SNOOPERS = 3,
  parameter int ADDR_W       = 32,
  parameter int TIMEOUT      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_op,
  input  logic [ADDR_W-1:0]         req_addr,
  output logic                      snp_valid,
  output logic [1:0]                snp_op,
  output logic [ADDR_W-1:0]         snp_addr,
  input  logic [NUM_SNOOPERS-1:0]   snp_rsp_valid,
  input  logic [2*NUM_SNOOPERS-1:0] snp_rsp,
  input  logic                      wb_done,
  output logic                      done_valid,
  output logic [1:0]                done_result,
  output logic [1:0]                done_fill_state,
  output logic                      done_timeout
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_BCAST   = 3'd1;
  localparam logic [2:0] ST_COLLECT = 3'd2;
  localparam logic [2:0] ST_WB_WAIT = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic              r_snp_valid;
  logic              r_done_valid;
  logic [1:0]        r_done_result;
  logic [1:0]        r_done_fill;
  logic              r_done_to;
  logic              w_accept;
  logic              w_all_in;
  logic              w_timed_out;
  logic [1:0]        w_agg;
  logic [1:0]        w_fill;

  snoop_rsp_collector #(
    .NUM_SNOOPERS (NUM_SNOOPERS),
    .TIMEOUT      (TIMEOUT)
  ) u_collector (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (r_state == ST_BCAST),
    .i_active    (r_state == ST_COLLECT),
    .i_rsp_valid (snp_rsp_valid),
    .i_rsp       (snp_rsp),
    .all_in      (w_all_in),
    .timed_out   (w_timed_out),
    .agg         (w_agg)
  );

  assign req_ready = (r_state == ST_IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_fill    = (r_op == OP_READ) ? ((w_agg == SNP_NOHIT) ? MESI_E : MESI_S) : MESI_M;

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (w_accept) w_next = ST_BCAST;
      ST_BCAST:   w_next = ST_COLLECT;
      ST_COLLECT: if (w_all_in || w_timed_out) w_next = (w_agg == SNP_HITM) ? ST_WB_WAIT : ST_DONE;
      ST_WB_WAIT: if (wb_done) w_next = ST_DONE;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  // Done fields are loaded on the edge into DONE; an incomplete mask there means timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_op          <= 2'b00;
      r_addr        <= '0;
      r_snp_valid   <= 1'b0;
      r_done_valid  <= 1'b0;
      r_done_result <= SNP_NOHIT;
      r_done_fill   <= MESI_I;
      r_done_to     <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_snp_valid <= (w_next == ST_BCAST);
      if (w_accept) begin
        r_op   <= req_op;
        r_addr <= req_addr;
      end
      if (w_next == ST_DONE) begin
        r_done_valid  <= 1'b1;
        r_done_result <= w_agg;
        r_done_fill   <= w_fill;
        r_done_to     <= ~w_all_in;
      end else begin
        r_done_valid  <= 1'b0;
        r_done_result <= SNP_NOHIT;
        r_done_fill   <= MESI_I;
        r_done_to     <= 1'b0;
      end
    end
  end

  assign snp_valid       = r_snp_valid;
  assign snp_op          = r_op;
  assign snp_addr        = r_addr;
  assign done_valid      = r_done_valid;
  assign done_result     = r_done_result;
  assign done_fill_state = r_done_fill;
  assign done_timeout    = r_done_to;

endmodule

`default_nettype wire

// File: tb/tb_snoop_bus_initiator.sv
// tb_snoop_bus_initiator: directed and randomized transactions checked cycle by
// cycle against a schedule-level reference model. Rev 1.0
`default_nettype none

module tb_snoop_bus_initiator;

  localparam int NS      = 3;
  localparam int AW      = 32;
  localparam int TIMEOUT = 8;
  localparam int NEVER   = 99;

  logic            clk;
  logic            rst;
  logic            req_valid;
  logic            req_ready;
  logic [1:0]      req_op;
  logic [AW-1:0]   req_addr;
  logic            snp_valid;
  logic [1:0]      snp_op;
  logic [AW-1:0]   snp_addr;
  logic [NS-1:0]   snp_rsp_valid;
  logic [2*NS-1:0] snp_rsp;
  logic            wb_done;
  logic            done_valid;
  logic [1:0]      done_result;
  logic [1:0]      done_fill_state;
  logic            done_timeout;

  int n_cmp = 0;
  int n_err = 0;

  // Per-peer schedule: first response at COLLECT index t_rc with code t_code,
  // optional later duplicate strobe at t_dc with code t_dcode.
  int t_rc[NS];
  int t_code[NS];
  int t_dc[NS];
  int t_dcode[NS];

  snoop_bus_initiator #(
    .NUM_SNOOPERS (NS),
    .ADDR_W       (AW),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_op          (req_op),
    .req_addr        (req_addr),
    .snp_valid       (snp_valid),
    .snp_op          (snp_op),
    .snp_addr        (snp_addr),
    .snp_rsp_valid   (snp_rsp_valid),
    .snp_rsp         (snp_rsp),
    .wb_done         (wb_done),
    .done_valid      (done_valid),
    .done_result     (done_result),
    .done_fill_state (done_fill_state),
    .done_timeout    (done_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_peer(input int p, input int rc, input int code, input int dc, input int dcode);
    t_rc[p] = rc; t_code[p] = code; t_dc[p] = dc; t_dcode[p] = dcode;
  endtask

  task automatic run_txn(input string nm, input logic [1:0] op, input logic [AW-1:0] addr,
                         input int d, input bit hold_next);
    int last, rank, c, len, exp_done, j;
    bit every;
    bit hitm;
    logic [1:0] e_res, e_fill;
    logic e_to;
    last = -1; rank = 0; every = 1'b1;
    for (int p = 0; p < NS; p++) begin
      if (t_rc[p] < TIMEOUT) begin
        if (t_rc[p] > last) last = t_rc[p];
        c = (t_code[p] == 3) ? 2 : t_code[p];
        if (c > rank) rank = c;
      end else begin
        every = 1'b0;
      end
    end
    len      = every ? last + 1 : TIMEOUT;
    e_to     = !every;
    e_res    = 2'(rank);
    hitm     = (rank == 2);
    e_fill   = (op == 2'b00) ? ((rank == 0) ? 2'b01 : 2'b10) : 2'b00;
    exp_done = hitm ? 3 + len + d : 2 + len;

    n_cmp++;
    if (req_ready !== 1'b1) begin
      n_err++; $display("FAIL %s idle_ready: got %b want 1", nm, req_ready);
    end
    req_valid = 1'b1; req_op = op; req_addr = addr;
    @(posedge clk);
    for (int n = 1; n <= exp_done + 1; n++) begin
      @(negedge clk);
      n_cmp++;
      if (snp_valid !== (n == 1)) begin
        n_err++; $display("FAIL %s snp_valid cyc%0d: got %b want %b", nm, n, snp_valid, n == 1);
      end
      n_cmp++;
      if (req_ready !== (n > exp_done)) begin
        n_err++; $display("FAIL %s req_ready cyc%0d: got %b want %b", nm, n, req_ready, n > exp_done);
      end
      n_cmp++;
      if (done_valid !== (n == exp_done)) begin
        n_err++; $display("FAIL %s done_valid cyc%0d: got %b want %b", nm, n, done_valid, n == exp_done);
      end
      if (n == 1 || n == exp_done) begin
        n_cmp++;
        if (snp_op !== op || snp_addr !== addr) begin
          n_err++; $display("FAIL %s snp_op/addr cyc%0d: got %b/%h want %b/%h", nm, n, snp_op, snp_addr, op, addr);
        end
      end
      if (n == exp_done) begin
        n_cmp++;
        if (done_result !== e_res) begin
          n_err++; $display("FAIL %s done_result: got %b want %b", nm, done_result, e_res);
        end
        n_cmp++;
        if (done_fill_state !== e_fill) begin
          n_err++; $display("FAIL %s done_fill_state: got %b want %b", nm, done_fill_state, e_fill);
        end
        n_cmp++;
        if (done_timeout !== e_to) begin
          n_err++; $display("FAIL %s done_timeout: got %b want %b", nm, done_timeout, e_to);
        end
      end
      req_valid = hold_next && (n == exp_done);
      if (req_valid) begin
        req_op = 2'($urandom); req_addr = $urandom;
      end
      j = n - 2;
      snp_rsp_valid = '0; snp_rsp = '0;
      if (n == 1) begin
        snp_rsp_valid = '1; snp_rsp = '1;
      end else if (j < len) begin
        for (int p = 0; p < NS; p++) begin
          if (t_rc[p] == j) begin
            snp_rsp_valid[p] = 1'b1; snp_rsp[2*p +: 2] = 2'(t_code[p]);
          end else if (t_dc[p] == j) begin
            snp_rsp_valid[p] = 1'b1; snp_rsp[2*p +: 2] = 2'(t_dcode[p]);
          end
        end
      end else begin
        snp_rsp_valid = NS'($urandom); snp_rsp = (2*NS)'($urandom);
      end
      if (hitm && j >= len && n < exp_done) wb_done = (n == exp_done - 1);
      else wb_done = 1'($urandom);
    end
  endtask

  task automatic test_reset;
    n_cmp++;
    if (req_ready !== 1'b1 || snp_valid !== 1'b0 || snp_op !== 2'b00 || snp_addr !== '0) begin
      n_err++; $display("FAIL reset_req_side: ready=%b sv=%b op=%b addr=%h want 1 0 00 0", req_ready, snp_valid, snp_op, snp_addr);
    end
    n_cmp++;
    if (done_valid !== 1'b0 || done_result !== 2'b00 || done_fill_state !== 2'b11 || done_timeout !== 1'b0) begin
      n_err++; $display("FAIL reset_done_side: dv=%b res=%b fill=%b to=%b want 0 00 11 0", done_valid, done_result, done_fill_state, done_timeout);
    end
  endtask

  task automatic test_read_fast;
    for (int p = 0; p < NS; p++) set_peer(p, 0, 0, NEVER, 0);
    run_txn("read_fast", 2'b00, 32'h0000_1040, 0, 1'b0);
  endtask

  task automatic test_read_hit;
    set_peer(0, 0, 0, NEVER, 0); set_peer(1, 2, 1, NEVER, 0); set_peer(2, 4, 0, NEVER, 0);
    run_txn("read_hit", 2'b00, 32'hDEAD_BEC0, 0, 1'b0);
  endtask

  task automatic test_rfo_hitm;
    set_peer(0, 0, 0, NEVER, 0); set_peer(1, 1, 2, NEVER, 0); set_peer(2, 0, 0, NEVER, 0);
    run_txn("rfo_hitm", 2'b10, 32'h1234_5680, 5, 1'b0);
  endtask

  task automatic test_timeout;
    set_peer(0, 1, 1, NEVER, 0); set_peer(1, 3, 0, NEVER, 0); set_peer(2, NEVER, 0, NEVER, 0);
    run_txn("write_timeout", 2'b01, 32'hCAFE_0000, 0, 1'b0);
  endtask

  task automatic test_dup_ignored;
    set_peer(0, 1, 1, 3, 2); set_peer(1, 2, 0, NEVER, 0); set_peer(2, 4, 0, NEVER, 0);
    run_txn("dup_ignored", 2'b00, 32'h0BAD_F00D, 0, 1'b0);
  endtask

  task automatic test_back_to_back;
    for (int p = 0; p < NS; p++) set_peer(p, 0, 0, NEVER, 0);
    run_txn("b2b_first", 2'b11, 32'h0000_0100, 0, 1'b1);
    run_txn("b2b_second", 2'b00, 32'h0000_0200, 0, 1'b1);
    run_txn("b2b_third", 2'b01, 32'h0000_0300, 0, 1'b0);
  endtask

  task automatic test_reset_wbwait;
    req_valid = 1'b1; req_op = 2'b10; req_addr = 32'h7777_0000;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    snp_rsp_valid = '0; snp_rsp = '0;
    @(negedge clk);
    snp_rsp_valid = '1; snp_rsp = 6'b00_10_00;
    @(negedge clk);
    snp_rsp_valid = '0; snp_rsp = '0; wb_done = 1'b0;
    n_cmp++;
    if (req_ready !== 1'b0 || done_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_wb pre_state: ready=%b dv=%b want 0 0", req_ready, done_valid);
    end
    #2 rst = 1'b1;
    #1;
    test_reset();
    for (int k = 0; k < 2; k++) begin
      wb_done = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (done_valid !== 1'b0) begin
        n_err++; $display("FAIL rst_wb in_reset dv: got %b want 0", done_valid);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++;
      if (done_valid !== 1'b0 || req_ready !== 1'b1) begin
        n_err++; $display("FAIL rst_wb after_release: dv=%b ready=%b want 0 1", done_valid, req_ready);
      end
    end
    wb_done = 1'b0;
    set_peer(0, 0, 0, NEVER, 0); set_peer(1, 1, 0, NEVER, 0); set_peer(2, 0, 1, NEVER, 0);
    run_txn("rst_wb_recover", 2'b00, 32'h7777_0040, 0, 1'b0);
  endtask

  task automatic test_random;
    int d;
    for (int t = 0; t < 25; t++) begin
      for (int p = 0; p < NS; p++) begin
        int rc;
        rc = int'($urandom_range(0, TIMEOUT + 1));
        if (rc >= TIMEOUT) rc = NEVER;
        set_peer(p, rc, int'($urandom_range(0, 3)), rc + int'($urandom_range(1, 3)), int'($urandom_range(0, 3)));
      end
      d = int'($urandom_range(0, 4));
      run_txn("random", 2'($urandom), $urandom, d, 1'($urandom));
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_op = 2'b00; req_addr = '0;
    snp_rsp_valid = '0; snp_rsp = '0; wb_done = 1'b0;
    #3;
    test_reset();
    @(negedge clk);
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_read_fast();
    test_read_hit();
    test_rfo_hitm();
    test_timeout();
    test_dup_ignored();
    test_back_to_back();
    test_reset_wbwait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/snoop_bus_initiator.md
# snoop_bus_initiator

Requesting-side bus agent for the L2 coherence path. It issues one bus operation (READ, WRITE, RFO, INVALIDATE) to all peer caches and collects their NOHIT/HIT/HITM snoop results into one aggregate. If a peer owns the line modified, it waits for that peer's writeback. It then returns the aggregate and the MESI state the requesting line must install. It sits between the L2 miss/upgrade logic and the snoop ports of peer caches.

## Interface
- NUM_SNOOPERS, 3, number of peer caches (1..8)
- ADDR_W, 32, address width
- TIMEOUT, 8, max cycles spent in COLLECT (≥1)

- clk  in  1  single clock, rising edge
- rst  in  1  reset: asynchronous, active-high
- req_valid  in  1  bus-op request
- req_ready  out  1  high in IDLE only; request accepted when req_valid && req_ready
- req_op  in  2  READ=00, WRITE=01, RFO=10, INVALIDATE=11
- req_addr  in  ADDR_W  line address
- snp_valid  out  1  one-cycle broadcast strobe
- snp_op  out  2  captured op, held from BCAST through DONE
- snp_addr  out  ADDR_W  captured address, held from BCAST through DONE
- snp_rsp_valid  in  NUM_SNOOPERS  per-peer response strobe
- snp_rsp  in  2*NUM_SNOOPERS  per-peer result; peer i uses bits [2i+1:2i]; NOHIT=00, HIT=01, HITM=10
- wb_done  in  1  HITM owner finished writeback
- done_valid  out  1  one-cycle completion pulse
- done_result  out  2  aggregate snoop result
- done_fill_state  out  2  state to install: M=00, E=01, S=10, I=11
- done_timeout  out  1  at least one peer did not respond

## Operation
- States are IDLE, BCAST, COLLECT, WB_WAIT and DONE.
- **IDLE:** req_ready=1. On an accepted request, capture op and address, then go to BCAST.
- **BCAST:** snp_valid=1 for exactly one cycle. Clear the response mask, the aggregate and the timeout counter. Go to COLLECT.
- **COLLECT:**
  - For each peer with snp_rsp_valid high and its mask bit clear: set the mask bit and merge the result into the aggregate.
  - Merge priority is HITM > HIT > NOHIT. Illegal code 11 merges as HITM.
  - Once a peer's mask bit is set, further strobes from that peer are ignored.
  - The counter increments every COLLECT cycle.
  - Exit when the mask is complete, counting strobes in the current cycle, or when the counter reaches TIMEOUT.
  - On a timeout exit, missing peers count as NOHIT and done_timeout is set.
  - The exit goes to WB_WAIT if the final aggregate is HITM, else to DONE.
- **WB_WAIT:** wait for wb_done=1, then go to DONE. There is no timeout. wb_done is ignored in every other state.
- **DONE:**
  - done_valid=1. done_result, done_fill_state and done_timeout are valid in this cycle only.
  - Next state is IDLE.
- **Fill state:**
  - READ: E if the aggregate is NOHIT, else S.
  - WRITE, RFO, INVALIDATE: M.
- snp_rsp_valid is ignored outside COLLECT, including in BCAST.

## Timing
- On rst, all of the following hold asynchronously:
  - state=IDLE and req_ready=1.
  - snp_valid=0, snp_op=00 and snp_addr=0.
  - done_valid=0, done_result=00, done_fill_state=11 and done_timeout=0.
  - The response mask, aggregate and counter are cleared.
- rst mid-operation abandons the transaction and emits no done pulse.
- Fastest path (all peers respond in the first COLLECT cycle, no HITM):
  - accept at edge 0;
  - BCAST in cycle 1;
  - COLLECT in cycle 2;
  - done_valid in cycle 3.
- Timeout path: COLLECT lasts exactly TIMEOUT cycles, then DONE or WB_WAIT follows.
- HITM path: done_valid is asserted the cycle after wb_done is sampled high in WB_WAIT.
- req_ready=0 from BCAST through DONE. A request presented in DONE is accepted only in the following IDLE cycle, so back-to-back accepts are at least 4 cycles apart.
- Outputs are registered, except req_ready, which decodes directly from the state register.

## Structure
- The shared package holds:
  - the MESI encodings (M/E/S/I);
  - the snoop result encodings (NOHIT/HIT/HITM);
  - the bus op encodings;
  - a priority-merge function for snoop results.

  The existing MESI state logic uses the same package.
- Sub-module snoop_rsp_collector holds:
  - the per-peer response mask;
  - the aggregate register;
  - the timeout counter, of width $clog2(TIMEOUT+1).

  It exposes all_in, timed_out and agg. The FSM stays in the top level.

## Test plan
- READ, 3 peers all return NOHIT in the first COLLECT cycle -> done_valid 3 cycles after accept, done_result=00, done_fill_state=E(01), done_timeout=0.
- READ, peers return NOHIT, HIT, NOHIT on different cycles -> done_result=01, done_fill_state=S(10).
- RFO, peer 1 returns HITM, wb_done asserted 5 cycles later -> stays in WB_WAIT until then; done_result=10, done_fill_state=M(00); done_valid follows wb_done by 1 cycle.
- WRITE, peer 2 never responds, TIMEOUT=8 -> COLLECT lasts 8 cycles, done_timeout=1, done_result reflects peers 0–1 only, done_fill_state=M.
- Peer 0 strobes HIT and then HITM on a later cycle -> the second strobe is ignored, done_result=01. Also: response presented during BCAST is ignored.
- rst asserted during WB_WAIT -> outputs return to reset values immediately with no done_valid pulse; a new READ then completes normally.
